// File: rtl/console_mux_pkg.sv
// Shared constants and helpers for the console_mux crossbar.
package console_mux_pkg;

    localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

    // Smallest selector width able to address n inputs (ceil log2, at least 1).
    function automatic int min_sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/console_mux_lane.sv
// One crossbar output: selector decode, range check and output register.
module console_mux_lane
    import console_mux_pkg::*;
#(
    parameter int   INPUT_COUNT = 4,
    parameter int   SEL_W       = 2,
    parameter logic IDLE_LEVEL  = DEFAULT_IDLE_LEVEL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [0:INPUT_COUNT-1] data,
    input  logic [0:SEL_W-1]       sel,
    output logic                   out_bit
);

    logic [SEL_W-1:0] sel_value;
    logic             out_next;
    logic             out_reg;

    // Leftmost selector bit is the MSB, so a plain copy gives the unsigned value.
    assign sel_value = sel;

    // Out-of-range codes never match an input and fall through to the idle level.
    always_comb begin
        out_next = IDLE_LEVEL;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            if (sel_value == SEL_W'(i)) begin
                out_next = data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= IDLE_LEVEL;
        end else begin
            out_reg <= out_next;
        end
    end

    assign out_bit = out_reg;

endmodule

// File: rtl/console_mux.sv
// Registered GPIO crossbar for console signal steering.
// Optional INPUT_SYNC_EN adds a 2-flop synchronizer on every gpios bit.
module console_mux
    import console_mux_pkg::*;
#(
    parameter int   INPUT_COUNT  = 4,
    parameter int   OUTPUT_COUNT = 4,
    parameter int   SEL_W        = 2,
    parameter logic IDLE_LEVEL   = DEFAULT_IDLE_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:INPUT_COUNT-1]        gpios,
    input  logic [0:OUTPUT_COUNT*SEL_W-1] selectors,
    output logic [0:OUTPUT_COUNT-1]       out
);

    localparam int MIN_SEL_W = min_sel_width(INPUT_COUNT);

    if (SEL_W < MIN_SEL_W) begin : g_bad_sel_w
        $error("console_mux: SEL_W too narrow for INPUT_COUNT");
    end

    logic [0:INPUT_COUNT-1] mux_data;

`ifdef INPUT_SYNC_EN
    logic [0:INPUT_COUNT-1] sync1_reg;
    logic [0:INPUT_COUNT-1] sync2_reg;

    // Idle-level reset keeps the lanes quiet until real samples arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= {INPUT_COUNT{IDLE_LEVEL}};
            sync2_reg <= {INPUT_COUNT{IDLE_LEVEL}};
        end else begin
            sync1_reg <= gpios;
            sync2_reg <= sync1_reg;
        end
    end

    assign mux_data = sync2_reg;
`else
    assign mux_data = gpios;
`endif

    for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_lane
        console_mux_lane #(
            .INPUT_COUNT (INPUT_COUNT),
            .SEL_W       (SEL_W),
            .IDLE_LEVEL  (IDLE_LEVEL)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .data    (mux_data),
            .sel     (selectors[gi*SEL_W +: SEL_W]),
            .out_bit (out[gi])
        );
    end

endmodule

// File: tb/tb_console_mux.sv
// Directed self-checking bench for console_mux (default 4x4 and a 3-input instance).
module tb_console_mux;

`ifdef INPUT_SYNC_EN
    localparam int DATA_LAT = 3;
`else
    localparam int DATA_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] gpios;
    logic [0:7] selectors;
    logic [0:3] out;

    logic [0:2] gpios3;
    logic [0:1] sel3;
    logic [0:0] out3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    console_mux dut (
        .clk       (clk),
        .rst       (rst),
        .gpios     (gpios),
        .selectors (selectors),
        .out       (out)
    );

    console_mux #(
        .INPUT_COUNT  (3),
        .OUTPUT_COUNT (1),
        .SEL_W        (2),
        .IDLE_LEVEL   (1'b1)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .gpios     (gpios3),
        .selectors (sel3),
        .out       (out3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        gpios     = 4'b0110;
        selectors = 8'b01_11_00_10;
        gpios3    = 3'b010;
        sel3      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out !== 4'b1111) begin
                errors++;
                $display("FAIL reset_cycle%0d: out=%b expected=1111", i, out);
            end
            $display("reset cycle %0d: out=%b", i, out);
        end
        rst       = 1'b0;
        selectors = 8'b00_00_00_00;
        gpios     = 4'b0101;
        repeat (DATA_LAT) step();
        checks++;
        if (out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: out=%b expected=0000", out);
        end
        $display("reset release: out=%b", out);
    endtask

    task automatic test_routing();
        gpios     = 4'b1010;
        selectors = 8'b00_01_10_11;
        repeat (DATA_LAT) step();
        checks++;
        if (out !== 4'b1010) begin
            errors++;
            $display("FAIL route_identity: out=%b expected=1010", out);
        end
        $display("route identity: out=%b", out);
        selectors = 8'b11_10_01_00;
        step();
        checks++;
        if (out !== 4'b0101) begin
            errors++;
            $display("FAIL route_reversed: out=%b expected=0101", out);
        end
        $display("route reversed: out=%b", out);
    endtask

    task automatic test_fanout();
        logic [0:3] hist [0:15];
        logic [0:3] src;
        logic       exp_bit;
        selectors = 8'b10_10_10_10;
        for (int n = 0; n < 16; n++) begin
            gpios   = 4'(n);
            hist[n] = 4'(n);
            step();
            if (n - DATA_LAT + 1 >= 0) begin
                src = hist[n - DATA_LAT + 1];
            end else begin
                src = 4'b1010;
            end
            exp_bit = src[2];
            checks++;
            if (out !== {4{exp_bit}}) begin
                errors++;
                $display("FAIL fanout_%0d: out=%b expected=%b", n, out, {4{exp_bit}});
            end
            $display("fanout gpios=%b: out=%b", gpios, out);
        end
    endtask

    task automatic test_switching();
        logic exp_bit;
        gpios     = 4'b1000;
        selectors = 8'b00_00_00_00;
        repeat (DATA_LAT) step();
        for (int i = 0; i < 8; i++) begin
            selectors[0:1] = (i % 2 == 0) ? 2'b00 : 2'b11;
            exp_bit        = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (out[0] !== exp_bit) begin
                errors++;
                $display("FAIL switch_%0d: out0=%b expected=%b", i, out[0], exp_bit);
            end
            $display("switch sel0=%b: out0=%b", selectors[0:1], out[0]);
        end
    endtask

    task automatic test_out_of_range();
        logic [0:2] pats [0:2];
        pats[0] = 3'b000;
        pats[1] = 3'b111;
        pats[2] = 3'b010;
        sel3 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            gpios3 = pats[i];
            repeat (DATA_LAT) step();
            checks++;
            if (out3[0] !== 1'b1) begin
                errors++;
                $display("FAIL oor_sel3_%0d: out=%b expected=1", i, out3[0]);
            end
            $display("out-of-range sel=3 gpios=%b: out=%b", gpios3, out3[0]);
        end
        sel3   = 2'b10;
        gpios3 = 3'b001;
        repeat (DATA_LAT) step();
        checks++;
        if (out3[0] !== 1'b1) begin
            errors++;
            $display("FAIL oor_sel2_hi: out=%b expected=1", out3[0]);
        end
        $display("in-range sel=2 gpios=%b: out=%b", gpios3, out3[0]);
        gpios3 = 3'b110;
        repeat (DATA_LAT) step();
        checks++;
        if (out3[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_sel2_lo: out=%b expected=0", out3[0]);
        end
        $display("in-range sel=2 gpios=%b: out=%b", gpios3, out3[0]);
    endtask

    task automatic test_latency_and_midreset();
        logic exp_bit;
        gpios     = 4'b0000;
        selectors = 8'b00_01_00_00;
        repeat (DATA_LAT + 1) step();
        gpios = 4'b0100;
        for (int i = 1; i <= DATA_LAT; i++) begin
            step();
            exp_bit = (i == DATA_LAT);
            checks++;
            if (out[1] !== exp_bit) begin
                errors++;
                $display("FAIL latency_edge%0d: out1=%b expected=%b", i, out[1], exp_bit);
            end
            $display("latency edge %0d: out1=%b", i, out[1]);
        end
        checks++;
        if (out !== 4'b0100) begin
            errors++;
            $display("FAIL latency_full: out=%b expected=0100", out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (out !== 4'b1111) begin
            errors++;
            $display("FAIL midstream_reset: out=%b expected=1111", out);
        end
        $display("mid-stream reset: out=%b", out);
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_routing();
        test_fanout();
        test_switching();
        test_out_of_range();
        test_latency_and_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/console_mux.md
Name: console_mux

Overview:
- Parameterised crossbar that routes any of INPUT_COUNT GPIO input lines to each of OUTPUT_COUNT output lines.
- Each output has its own selector field.
- Used in the console multiplexer to steer serial/console signals between pins.
- All outputs are registered on clk.

Parameters:
- INPUT_COUNT, 4, number of GPIO input lines (>=2).
- OUTPUT_COUNT, 4, number of routed outputs (>=1).
- SEL_W, 2, selector field width per output; must satisfy 2**SEL_W >= INPUT_COUNT.
- IDLE_LEVEL, 1, level driven on an output during reset and when its selector is out of range (UART idle-high).

Ports:
- clk  input  1  single clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- gpios  input  [0:INPUT_COUNT-1]  input lines; gpios[i] is input i.
- selectors  input  [0:OUTPUT_COUNT*SEL_W-1]  concatenated selector fields; field k = selectors[k*SEL_W : k*SEL_W+SEL_W-1], lowest index is MSB.
- out  output  [0:OUTPUT_COUNT-1]  routed outputs; out[k] is output k.

Behaviour:
- Reset is synchronous and active-high. On a rising clk with rst=1, every out[k] is set to IDLE_LEVEL. Reset overrides all other activity, including mid-operation.
- Normal operation, each rising clk: sel_k = field k as an unsigned value.
  - If sel_k < INPUT_COUNT: out[k] <= gpios[sel_k].
  - Otherwise: out[k] <= IDLE_LEVEL.
- Latency: exactly 1 clk from a gpios/selectors change to out, without the optional feature.
- No combinational path from any input to out.
- Outputs are independent:
  - Several outputs may select the same input simultaneously; all follow it.
  - An input selected by no output is ignored.
- Selector changes take effect on the next edge. No glitch suppression and no handshake are applied; the new source appears on the cycle after the change.
- X/undefined selectors are not filtered. Reset must be applied before selectors are trusted.
- No internal state beyond the output registers and the optional synchronizer.

Optional Feature:
- Macro INPUT_SYNC_EN.
- When defined:
  - gpios pass through a 2-flop synchronizer per bit before the mux. Synchronizer flops reset to IDLE_LEVEL.
  - Data latency becomes 3 clk (2 sync + 1 output register).
  - Selector latency stays 1 clk: selectors are not synchronized and act on the already-synchronized data.
- When undefined: gpios feed the mux directly; latency is 1 clk.

Decomposition:
- Package console_mux_pkg holds:
  - the function computing the minimum selector width (ceil log2 of INPUT_COUNT);
  - the default IDLE_LEVEL constant.
- One natural sub-module: console_mux_lane. It contains one output's selector decode, range check and output flop, and is instantiated OUTPUT_COUNT times by generate.
- The optional synchronizer stays inline in the top.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary gpios/selectors -> out == 4'b1111. After release with selectors=8'b00_00_00_00 and gpios=4'b0101 -> out == 4'b0000 on the next edge.
- Per-output routing: gpios=4'b1010, selectors = out0->0, out1->1, out2->2, out3->3 (8'b00_01_10_11) -> out == 4'b1010 one cycle later. Then selectors reversed (8'b11_10_01_00) -> out == 4'b0101.
- Fan-out: all fields = 2 (8'b10_10_10_10) while gpios walks 0..15 every cycle -> each out[k] equals the previous cycle's gpios[2].
- Selector switching: out0 toggles between 0 and 3 every cycle with gpios=4'b1000 -> out[0] alternates 1,0 with exactly 1-cycle lag.
- Out of range: INPUT_COUNT=3, SEL_W=2, field 0 = 3 -> out[0] == IDLE_LEVEL (1) regardless of gpios; field 0 = 2 -> out[0] follows gpios[2].
- INPUT_SYNC_EN defined: single-cycle step of gpios[1] 0->1 with out1 selecting input 1 -> out[1] rises exactly 3 clk later. Reset mid-stream -> out returns to 1 on the next edge.
